// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receive-side frame shift register.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } rx_sr_state_t;

  localparam int UART_MIN_DATA_W = 5;

endpackage

// File: rtl/uart_rx_frame_sr.sv
// UART RX frame shift register: index-addressed capture of
// data, parity and stop bits with error flags on completion.
module uart_rx_frame_sr #(
  parameter int MAX_DATA_W = 9,
  parameter int SZ_W       = $clog2(MAX_DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  shift_strobe,
  input  logic                  serial_in,
  input  logic [SZ_W-1:0]       data_size,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic [MAX_DATA_W-1:0] packet_data,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  frame_done,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int CAP_W = MAX_DATA_W + 3;
  localparam int CNT_W = $clog2(MAX_DATA_W + 4);

  rx_sr_state_t          state_q, state_d;
  parity_mode_t          par_q, par_d;
  logic [CNT_W-1:0]      ds_q, ds_d;
  logic [CNT_W-1:0]      nb_q, nb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CAP_W-1:0]      cap_q, cap_d;
  logic                  two_q, two_d;
  logic                  rpar_q, rpar_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic [CNT_W-1:0] dsz;
  logic [CNT_W-1:0] s1_idx;
  logic             pen, new_pen;
  parity_mode_t     new_par;

  always_comb begin
    dsz = CNT_W'(data_size);
    if (dsz < CNT_W'(UART_MIN_DATA_W))
      dsz = CNT_W'(UART_MIN_DATA_W);
    else if (dsz > CNT_W'(MAX_DATA_W))
      dsz = CNT_W'(MAX_DATA_W);
  end

  assign new_par = parity_mode_t'(parity_mode);
  assign new_pen = (new_par == PAR_EVEN) || (new_par == PAR_ODD);
  assign pen     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign s1_idx  = ds_q + CNT_W'(pen);

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    ds_d    = ds_q;
    nb_d    = nb_q;
    two_d   = two_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rpar_d  = rpar_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (shift_strobe) begin
          cap_d[cnt_q] = serial_in;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q < ds_q)
            rpar_d = rpar_q ^ serial_in;
          if (cnt_q == nb_q - 1'b1) begin
            state_d = DONE;
            for (int i = 0; i < MAX_DATA_W; i++)
              data_d[i] = (i < int'(ds_q)) ? cap_d[i] : 1'b0;
            unique case (par_q)
              PAR_EVEN: perr_d = rpar_d ^ cap_d[ds_q];
              PAR_ODD:  perr_d = ~(rpar_d ^ cap_d[ds_q]);
              default:  perr_d = 1'b0;
            endcase
            ferr_d = ~cap_d[s1_idx]
                   | (two_q & ~cap_d[s1_idx + 1'b1]);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new start always wins; it aborts without touching outputs.
    if (frame_start) begin
      state_d = SHIFT;
      par_d   = new_par;
      ds_d    = dsz;
      two_d   = two_stop;
      nb_d    = dsz + CNT_W'(new_pen) + (two_stop ? CNT_W'(2) : CNT_W'(1));
      cnt_d   = '0;
      cap_d   = '0;
      rpar_d  = 1'b0;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      par_q   <= PAR_NONE;
      ds_q    <= CNT_W'(UART_MIN_DATA_W);
      nb_q    <= '0;
      two_q   <= 1'b0;
      cnt_q   <= '0;
      cap_q   <= '0;
      rpar_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      ds_q    <= ds_d;
      nb_q    <= nb_d;
      two_q   <= two_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      rpar_q  <= rpar_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign packet_data   = data_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign frame_done    = (state_q == DONE);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sr.sv
// Directed bench for uart_rx_frame_sr.
// Drives frames bit by bit and checks outputs against hand-computed values.
module tb_uart_rx_frame_sr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       shift_strobe = 1'b0;
  logic       serial_in = 1'b0;
  logic [3:0] data_size = 4'd8;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic [8:0] packet_data;
  logic       parity_error;
  logic       framing_error;
  logic       frame_done;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nd0;

  uart_rx_frame_sr #(.MAX_DATA_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .shift_strobe (shift_strobe),
    .serial_in    (serial_in),
    .data_size    (data_size),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .packet_data  (packet_data),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_done) ndone++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int sz, input int pm, input bit two);
    frame_start = 1'b1;
    data_size   = 4'(sz);
    parity_mode = 2'(pm);
    two_stop    = two;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic sbit(input bit b);
    shift_strobe = 1'b1;
    serial_in    = b;
    cyc();
    shift_strobe = 1'b0;
  endtask

  task automatic sdata(input logic [8:0] d, input int n);
    for (int i = 0; i < n; i++) sbit(d[i]);
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_data", 32'(packet_data), 0);
    chk("rst_perr", 32'(parity_error), 0);
    chk("rst_ferr", 32'(framing_error), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);

    // strobe in IDLE is ignored
    sbit(1'b1);
    chk("idle_busy", 32'(busy), 0);

    // size 8, no parity, 1 stop, 0xA5
    start(8, 0, 1'b0);
    chk("a5_busy", 32'(busy), 1);
    sdata(9'h0A5, 8);
    chk("a5_early", 32'(frame_done), 0);
    sbit(1'b1);
    chk("a5_done", 32'(frame_done), 1);
    chk("a5_data", 32'(packet_data), 32'h0A5);
    chk("a5_perr", 32'(parity_error), 0);
    chk("a5_ferr", 32'(framing_error), 0);
    cyc();
    chk("a5_pulse", 32'(frame_done), 0);
    chk("a5_idle", 32'(busy), 0);
    chk("a5_hold", 32'(packet_data), 32'h0A5);

    // size 7, even parity, good then bad parity bit
    start(7, 1, 1'b0);
    sdata(9'h041, 7);
    sbit(1'b0);
    sbit(1'b1);
    chk("ev_done", 32'(frame_done), 1);
    chk("ev_data", 32'(packet_data), 32'h041);
    chk("ev_perr", 32'(parity_error), 0);
    cyc();
    start(7, 1, 1'b0);
    sdata(9'h041, 7);
    sbit(1'b1);
    sbit(1'b1);
    chk("evb_data", 32'(packet_data), 32'h041);
    chk("evb_perr", 32'(parity_error), 1);
    chk("evb_ferr", 32'(framing_error), 0);
    cyc();

    // size 5, odd parity, two stops, second stop low
    start(5, 2, 1'b1);
    sdata(9'h015, 5);
    sbit(1'b0);
    sbit(1'b1);
    chk("od_early", 32'(frame_done), 0);
    sbit(1'b0);
    chk("od_done", 32'(frame_done), 1);
    chk("od_data", 32'(packet_data), 32'h015);
    chk("od_perr", 32'(parity_error), 0);
    chk("od_ferr", 32'(framing_error), 1);
    cyc();

    // abort after 4 strobes with coincident start+strobe
    nd0 = ndone;
    start(8, 0, 1'b0);
    sdata(9'h0FF, 4);
    frame_start  = 1'b1;
    shift_strobe = 1'b1;
    serial_in    = 1'b1;
    cyc();
    frame_start  = 1'b0;
    shift_strobe = 1'b0;
    chk("ab_nodone", 32'(frame_done), 0);
    chk("ab_hold", 32'(packet_data), 32'h015);
    sdata(9'h03C, 8);
    chk("ab_early", 32'(frame_done), 0);
    sbit(1'b1);
    chk("ab_data", 32'(packet_data), 32'h03C);
    chk("ab_ferr", 32'(framing_error), 0);
    cyc();
    chk("ab_count", ndone - nd0, 1);

    // size 9 at the maximum width
    start(9, 0, 1'b0);
    sdata(9'h1FF, 9);
    sbit(1'b1);
    chk("mx_done", 32'(frame_done), 1);
    chk("mx_data", 32'(packet_data), 32'h1FF);
    cyc();

    // size 3 clamps to 5: six strobes finish the frame
    start(3, 0, 1'b0);
    sdata(9'h00B, 5);
    chk("cl_early", 32'(frame_done), 0);
    sbit(1'b1);
    chk("cl_done", 32'(frame_done), 1);
    chk("cl_data", 32'(packet_data), 32'h00B);
    cyc();

    // reset mid-frame
    nd0 = ndone;
    start(8, 0, 1'b0);
    sdata(9'h0FF, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_data", 32'(packet_data), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_perr", 32'(parity_error), 0);
    chk("mr_ferr", 32'(framing_error), 0);
    sbit(1'b1);
    sbit(1'b1);
    sbit(1'b1);
    cyc();
    chk("mr_nodone", ndone - nd0, 0);
    start(8, 0, 1'b0);
    sdata(9'h05A, 8);
    sbit(1'b1);
    chk("pr_done", 32'(frame_done), 1);
    chk("pr_data", 32'(packet_data), 32'h05A);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
